phy_tx_byte_scheduler: RTL

//  Byte-slot scheduler in front of the phy-tx serializer (clk_32f domain). Tracks the serializer's 8-cycle

---
 rtl/phy_tx_byte_scheduler.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/phy_tx_byte_scheduler.sv
// -----------------------------------------------------------------------------
// phy_tx_byte_scheduler
//
// Byte-slot scheduler in front of the phy-tx serializer, clk_32f domain.
// A free-running 3-bit phase counter runs in lockstep with the serializer's
// bit counter. Each 8-cycle slot carries one byte. The decision for a slot is
// made at the posedge where phase==6. The registered outputs are then stable
// while the serializer samples them at the phase-7 edge. They stay held until
// the next phase-6 edge.
//
// Link states:
//   SYNC  : SYNC_BYTES comma slots (valid_out=0) before any data is granted.
//   RUN   : round-robin grant of one requester per slot, or comma if idle.
//   PAUSE : tx_enable low, commas only. Leaving PAUSE re-runs the full SYNC.
//
// Optional feature: compile with SKIP_INSERT_EN defined to replace every
// SKIP_PERIOD-th RUN slot with the SKIP_SYM symbol. No grant is issued in
// that slot. Without the macro, every RUN slot is arbitrated or a comma.
//
// Parameters:
//   N_REQ        number of requesters (2..8)
//   SYNC_BYTES   comma slots sent in SYNC (1..255)
//   SKIP_PERIOD  RUN slots per SKIP symbol (SKIP_INSERT_EN only, 2..255)
//   SKIP_SYM     SKIP symbol value
//
// Ports:
//   clk_32f      in   bit clock shared with the serializer
//   reset        in   synchronous, active-low
//   tx_enable    in   1 = run link, 0 = pause (idles only)
//   req_valid    in   [N_REQ]   requester i has a byte pending
//   req_data     in   [8*N_REQ] byte of requester i at [8i+7:8i]
//   req_ready    out  [N_REQ]   one-hot, one-cycle consume pulse (phase 7)
//   valid_out    out  serializer valid_in (0 = send comma 8'hBC)
//   data_out     out  [8] serializer data byte
//   sync_done    out  1 while the link is in RUN
//   slot_strobe  out  1 in the cycle the serializer samples (phase==7)
// -----------------------------------------------------------------------------
module phy_tx_byte_scheduler #(
  parameter int         N_REQ       = 4,
  parameter int         SYNC_BYTES  = 4,
  parameter int         SKIP_PERIOD = 16,
  parameter logic [7:0] SKIP_SYM    = 8'h7C
) (
  input  logic                 clk_32f,
  input  logic                 reset,
  input  logic                 tx_enable,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 valid_out,
  output logic [7:0]           data_out,
  output logic                 sync_done,
  output logic                 slot_strobe
);

  localparam int              PW        = $clog2(N_REQ);
  localparam logic [7:0]      SYNC_LAST = 8'(SYNC_BYTES - 1);
  localparam logic [PW-1:0]   RR_INIT   = PW'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_RUN,
    ST_PAUSE
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [2:0]     phase;
  logic [7:0]     sync_cnt;
  logic [7:0]     sync_cnt_next;
  logic [PW-1:0]  rr_ptr;
  logic [PW-1:0]  rr_ptr_next;
  logic           valid_next;
  logic [7:0]     data_next;
  logic [N_REQ-1:0] ready_next;
  logic           sync_done_next;

  logic           decide;
  logic           grant_found;
  logic [PW-1:0]  grant_idx;
  logic [PW-1:0]  cand;
  logic           skip_slot;
  logic [7:0]     req_bytes [N_REQ];

  // The slot decision edge is the posedge where the register still holds 6.
  // The serializer then samples the outputs at the following phase-7 edge.
  assign decide      = (phase == 3'd6);
  assign slot_strobe = (phase == 3'd7);

  for (genvar i = 0; i < N_REQ; i++) begin : g_bytes
    assign req_bytes[i] = req_data[8*i +: 8];
  end

  // ---------------------------------------------------------------------------
  // Round-robin search. The search starts one past the last winner and wraps
  // modulo N_REQ. The last winner is therefore examined last. The result is
  // only used at a RUN decision edge, so it can be evaluated every cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default before any branch; a
    // path that leaves one unassigned would infer a latch.
    grant_found = 1'b0;
    grant_idx   = rr_ptr;
    cand        = rr_ptr;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = PW'((int'(rr_ptr) + k) % N_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional SKIP insertion: counts RUN slot decisions and flags the slot that
  // must carry SKIP_SYM instead of a grant.
  // ---------------------------------------------------------------------------
`ifdef SKIP_INSERT_EN
  localparam logic [7:0] SKIP_LAST = 8'(SKIP_PERIOD - 1);

  logic [7:0] skip_cnt;
  logic [7:0] skip_cnt_next;

  assign skip_slot = (skip_cnt == SKIP_LAST);

  always_comb begin
    skip_cnt_next = skip_cnt;
    if (decide) begin
      if (state_next != ST_RUN) begin
        skip_cnt_next = '0;
      end else if (state == ST_RUN) begin
        skip_cnt_next = skip_slot ? 8'd0 : skip_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_32f) begin
    if (!reset) begin
      skip_cnt <= '0;
    end else begin
      skip_cnt <= skip_cnt_next;
    end
  end
`else
  assign skip_slot = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Link FSM and registered slot outputs: next-state / next-output logic.
  // Nothing changes between decision edges except the one-cycle req_ready
  // pulse, which falls back to zero at the phase-7 edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state;
    sync_cnt_next  = sync_cnt;
    rr_ptr_next    = rr_ptr;
    valid_next     = valid_out;
    data_next      = data_out;
    ready_next     = '0;
    sync_done_next = sync_done;

    if (decide) begin
      case (state)
        ST_SYNC: begin
          valid_next = 1'b0;
          if (!tx_enable) begin
            state_next    = ST_PAUSE;
            sync_cnt_next = '0;
          end else if (sync_cnt == SYNC_LAST) begin
            state_next    = ST_RUN;
            sync_cnt_next = '0;
          end else begin
            sync_cnt_next = sync_cnt + 8'd1;
          end
        end

        ST_RUN: begin
          if (!tx_enable) begin
            state_next = ST_PAUSE;
            valid_next = 1'b0;
          end else if (skip_slot) begin
            valid_next = 1'b1;
            data_next  = SKIP_SYM;
          end else if (grant_found) begin
            valid_next            = 1'b1;
            data_next             = req_bytes[grant_idx];
            ready_next[grant_idx] = 1'b1;
            rr_ptr_next           = grant_idx;
          end else begin
            // Empty slot: comma. data_out keeps the last byte.
            valid_next = 1'b0;
          end
        end

        ST_PAUSE: begin
          valid_next = 1'b0;
          if (tx_enable) begin
            state_next    = ST_SYNC;
            sync_cnt_next = '0;
          end
        end

        default: begin
          state_next    = ST_SYNC;
          sync_cnt_next = '0;
          valid_next    = 1'b0;
        end
      endcase

      // sync_done goes high with the SYNC->RUN decision. It drops on any
      // decision that leaves RUN.
      sync_done_next = (state_next == ST_RUN);
    end
  end

  // Link FSM and registered slot outputs: state registers.
  always_ff @(posedge clk_32f) begin
    // NOTE: reset is sampled on the clock edge, not asynchronously, so the
    // phase counter restarts in lockstep with the serializer, which is reset
    // on the same edge.
    if (!reset) begin
      phase     <= '0;
      state     <= ST_SYNC;
      sync_cnt  <= '0;
      rr_ptr    <= RR_INIT;
      valid_out <= 1'b0;
      data_out  <= '0;
      req_ready <= '0;
      sync_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // the pre-edge values regardless of statement order.
      phase     <= phase + 3'd1;
      state     <= state_next;
      sync_cnt  <= sync_cnt_next;
      rr_ptr    <= rr_ptr_next;
      valid_out <= valid_next;
      data_out  <= data_next;
      req_ready <= ready_next;
      sync_done <= sync_done_next;
    end
  end

endmodule
